// File: rtl/key_schedule_pkg.sv
// Shared constants and types for the key schedule front end.
//   KEY_W     : master key width (only 32 is supported)
//   SUB_W     : subkey width, KEY_W/4
//   NIB_SHIFT : offset applied to the byte split when the key has even parity
//   subkeys_t : the four subkeys packed so that k0 is the least significant byte
package key_schedule_pkg;

  localparam int unsigned KEY_W     = 32;
  localparam int unsigned SUB_W     = 8;
  localparam int unsigned NIB_SHIFT = 4;

  typedef struct packed {
    logic [SUB_W-1:0] k3;
    logic [SUB_W-1:0] k2;
    logic [SUB_W-1:0] k1;
    logic [SUB_W-1:0] k0;
  } subkeys_t;

endpackage

// File: rtl/key_split.sv
// Combinational subkey derivation. Pure bit selection; every key bit lands
// in exactly one subkey bit.
// Ports:
//   k_i       [31:0]  master key
//   subkeys_o         derived subkeys k3..k0
//   parity_o          XOR-reduction of k_i (1 = odd number of ones)
// Odd parity selects the plain byte split; even parity selects the split
// shifted up by one nibble, with k3 built from the top and bottom nibbles.
module key_split
  import key_schedule_pkg::*;
(
  input  logic [KEY_W-1:0] k_i,
  output subkeys_t         subkeys_o,
  output logic             parity_o
);

  always_comb begin
    parity_o  = ^k_i;
    subkeys_o = '0;
    if (parity_o) begin
      subkeys_o.k0 = k_i[0*SUB_W +: SUB_W];
      subkeys_o.k1 = k_i[1*SUB_W +: SUB_W];
      subkeys_o.k2 = k_i[2*SUB_W +: SUB_W];
      subkeys_o.k3 = k_i[3*SUB_W +: SUB_W];
    end else begin
      subkeys_o.k0 = k_i[0*SUB_W + NIB_SHIFT +: SUB_W];
      subkeys_o.k1 = k_i[1*SUB_W + NIB_SHIFT +: SUB_W];
      subkeys_o.k2 = k_i[2*SUB_W + NIB_SHIFT +: SUB_W];
      // Not a rotate: the top nibble stays on top, the bottom nibble wraps below it.
      subkeys_o.k3 = {k_i[KEY_W-1 -: NIB_SHIFT], k_i[NIB_SHIFT-1:0]};
    end
  end

endmodule

// File: rtl/key_schedule_reg.sv
// Round subkey generator: derives K0..K3 from master key K and registers
// them with a valid flag (one cycle latency, one key per cycle, no stall).
// Ports:
//   CLK        clock, rising edge
//   RST        synchronous active-high reset (priority over K_VALID)
//   K [31:0]   master key, qualified by K_VALID
//   K_VALID    K is valid this cycle
//   K0..K3     registered subkeys; hold when no key is loaded
//   SUB_VALID  K0..K3 were loaded from a qualified key on the last edge
//   KPAR       registered key parity (only with KEY_SCHEDULE_PARITY_OUT_EN)
// Build option: define KEY_SCHEDULE_PARITY_OUT_EN to add the KPAR output.
module key_schedule_reg #(
  parameter int unsigned KEY_W = 32,
  parameter int unsigned SUB_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [KEY_W-1:0] K,
  input  logic             K_VALID,
  output logic [SUB_W-1:0] K0,
  output logic [SUB_W-1:0] K1,
  output logic [SUB_W-1:0] K2,
  output logic [SUB_W-1:0] K3,
`ifdef KEY_SCHEDULE_PARITY_OUT_EN
  output logic             KPAR,
`endif
  output logic             SUB_VALID
);

  import key_schedule_pkg::*;

  if (KEY_W != key_schedule_pkg::KEY_W || SUB_W != key_schedule_pkg::SUB_W) begin : g_bad_cfg
    $error("key_schedule_reg supports only KEY_W=32, SUB_W=8");
  end

  subkeys_t derived;
  logic     key_par;

  key_split u_key_split (
    .k_i       (K),
    .subkeys_o (derived),
    .parity_o  (key_par)
  );

  subkeys_t sub_d, sub_q;
  logic     valid_d, valid_q;

  // Hold path selects the register, so an undriven K while idle never
  // reaches the outputs.
  always_comb begin
    sub_d   = sub_q;
    valid_d = 1'b0;
    if (K_VALID) begin
      sub_d   = derived;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sub_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      sub_q   <= sub_d;
      valid_q <= valid_d;
    end
  end

`ifdef KEY_SCHEDULE_PARITY_OUT_EN
  logic par_d, par_q;

  always_comb begin
    par_d = par_q;
    if (K_VALID) begin
      par_d = key_par;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  assign KPAR = par_q;
`else
  logic unused_par;
  assign unused_par = key_par;
`endif

  assign K0        = sub_q.k0;
  assign K1        = sub_q.k1;
  assign K2        = sub_q.k2;
  assign K3        = sub_q.k3;
  assign SUB_VALID = valid_q;

endmodule

// File: tb/tb_key_schedule_reg.sv
// Directed bench for key_schedule_reg. The stimulus process pushes the
// hand-computed subkeys of each accepted key into a queue; a monitor pops
// and compares whenever SUB_VALID is seen. Idle/reset states are checked
// directly by the stimulus process.
module tb_key_schedule_reg;

  typedef struct {
    logic [31:0] subs;  // {K3,K2,K1,K0}
    logic        par;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] K;
  logic        K_VALID;
  logic [7:0]  K0, K1, K2, K3;
  logic        SUB_VALID;
`ifdef KEY_SCHEDULE_PARITY_OUT_EN
  logic        KPAR;
`endif

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  key_schedule_reg dut (
    .CLK       (CLK),
    .RST       (RST),
    .K         (K),
    .K_VALID   (K_VALID),
    .K0        (K0),
    .K1        (K1),
    .K2        (K2),
    .K3        (K3),
`ifdef KEY_SCHEDULE_PARITY_OUT_EN
    .KPAR      (KPAR),
`endif
    .SUB_VALID (SUB_VALID)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Checks the idle/reset state: SUB_VALID low and outputs holding subs/par.
  task automatic check_idle(input string name, input logic [31:0] subs, input logic par);
    check({name, "_sub_valid"}, {31'd0, SUB_VALID}, 32'd0);
    check({name, "_subkeys"}, {K3, K2, K1, K0}, subs);
`ifdef KEY_SCHEDULE_PARITY_OUT_EN
    check({name, "_kpar"}, {31'd0, KPAR}, {31'd0, par});
`else
    if (par === 1'bx) $display("unreachable");
`endif
  endtask

  task automatic cyc(input logic rst, input logic valid, input logic [31:0] k);
    RST     = rst;
    K_VALID = valid;
    K       = k;
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [31:0] k, input logic [31:0] subs, input logic par);
    exp_t e;
    e.subs = subs;
    e.par  = par;
    exp_q.push_back(e);
    cyc(1'b0, 1'b1, k);
  endtask

  // Monitor: compare every presented subkey set against the scoreboard.
  initial begin
    exp_t e;
    @(posedge CLK);
    forever begin
      @(negedge CLK);
      if (SUB_VALID === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_sub_valid: got subkeys %h, expected no output", {K3, K2, K1, K0});
        end else begin
          e = exp_q.pop_front();
          check("sb_subkeys", {K3, K2, K1, K0}, e.subs);
`ifdef KEY_SCHEDULE_PARITY_OUT_EN
          check("sb_kpar", {31'd0, KPAR}, {31'd0, e.par});
`endif
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST     = 1'b1;
    K_VALID = 1'b1;
    K       = 32'hFFFF_FFFF;

    // Reset has priority over a valid key.
    cyc(1'b1, 1'b1, 32'hFFFF_FFFF);
    check_idle("reset1", 32'h0000_0000, 1'b0);
    cyc(1'b1, 1'b1, 32'hFFFF_FFFF);
    check_idle("reset2", 32'h0000_0000, 1'b0);

    send(32'h0000_0000, 32'h0000_0000, 1'b0);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    send(32'h57A3_36BC, 32'h5C7A_336B, 1'b0);  // even: shifted split
    send(32'h35AB_674F, 32'h35AB_674F, 1'b1);  // odd: plain split

    // Hold with K_VALID low, including an undriven key.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 32'h0000_0000);
      check_idle("hold", 32'h35AB_674F, 1'b1);
    end
    cyc(1'b0, 1'b0, 32'hxxxx_xxxx);
    check_idle("hold_x", 32'h35AB_674F, 1'b1);

    // Back-to-back keys, then reset mid-stream discards the in-flight key.
    send(32'h57A3_36BC, 32'h5C7A_336B, 1'b0);
    send(32'h35AB_674F, 32'h35AB_674F, 1'b1);
    cyc(1'b1, 1'b1, 32'h1234_5678);
    check_idle("mid_reset", 32'h0000_0000, 1'b0);
    cyc(1'b0, 1'b0, 32'h1234_5678);
    check_idle("post_reset_idle", 32'h0000_0000, 1'b0);

    send(32'h8000_0001, 32'h8100_0000, 1'b0);
    send(32'h0000_0001, 32'h0000_0001, 1'b1);
    send(32'h1234_5678, 32'h1234_5678, 1'b1);
    cyc(1'b0, 1'b0, 32'h0000_0000);
    check_idle("final_hold", 32'h1234_5678, 1'b1);
    cyc(1'b0, 1'b0, 32'h0000_0000);

    check("sb_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/key_schedule_reg.md
Name: key_schedule_reg

Overview:
- Derives four 8-bit round subkeys (K0..K3) from a 32-bit master key K.
- The selection rule depends on the parity of K:
  - Odd number of ones: plain byte split.
  - Even number of ones: a nibble-shifted split.
- The combinational derivation is followed by one register stage with a valid flag. The block sits in front of the round datapath of the cipher core.

Parameters:
- KEY_W, 32, master key width; only 32 is supported.
- SUB_W, 8, subkey width; fixed at KEY_W/4.

Ports:
- CLK  in  1  clock; all state updates on its rising edge.
- RST  in  1  synchronous, active-high reset.
- K  in  32  master key.
- K_VALID  in  1  qualifies K for the current cycle.
- K0  out  8  subkey 0 (registered).
- K1  out  8  subkey 1 (registered).
- K2  out  8  subkey 2 (registered).
- K3  out  8  subkey 3 (registered).
- SUB_VALID  out  1  K0..K3 hold the derivation of a qualified key.

Behaviour:
- Parity: p = XOR-reduction of K[31:0].
- p=1 (odd number of ones):
  - K0=K[7:0], K1=K[15:8], K2=K[23:16], K3=K[31:24].
- p=0 (even number of ones):
  - K0=K[11:4], K1=K[19:12], K2=K[27:20].
  - K3={K[31:28],K[3:0]}, i.e. upper nibble from K[31:28], lower nibble from K[3:0].
- Derivation is purely bit selection: no arithmetic, no carries, every key bit appears exactly once.
- Register stage, on each rising CLK edge:
  - If RST=1: K0..K3 <= 8'h00 and SUB_VALID <= 0. RST has priority over K_VALID.
  - Else if K_VALID=1: K0..K3 <= derived subkeys and SUB_VALID <= 1.
  - Else: K0..K3 hold their values and SUB_VALID <= 0.
- Latency: exactly 1 cycle from K/K_VALID sampled to K0..K3/SUB_VALID.
- Throughput: one key per cycle. Back-to-back K_VALID produces back-to-back SUB_VALID with no bubbles.
- No backpressure; the consumer must accept each SUB_VALID cycle.
- RST asserted mid-stream discards the in-flight key. The first SUB_VALID after reset release follows the first K_VALID by 1 cycle.
- K is don't-care while K_VALID=0, and the outputs must not change.
- X/Z on K while K_VALID=0 must not propagate to the outputs.

Optional Feature:
- Macro: KEY_SCHEDULE_PARITY_OUT_EN.
- Defined:
  - Adds output port KPAR (1 bit), registered alongside K0..K3 with the same load, hold and reset rules.
  - KPAR equals p; reset value 0.
- Undefined: port KPAR is absent; all other behaviour is identical.

Decomposition:
- Package key_schedule_pkg holds:
  - Constants KEY_W=32, SUB_W=8, NIB_SHIFT=4.
  - typedef subkeys_t: a packed struct of four SUB_W fields k3,k2,k1,k0.
- Sub-module key_split: purely combinational.
  - Input K[31:0].
  - Outputs subkeys_t and parity.
  - Implements the two selection rules.
- The top level instantiates key_split and adds the register and valid stage.

Test Plan:
- Reset: RST=1 for 2 cycles with K_VALID=1 and K=32'hFFFFFFFF. Required: K0..K3=00, SUB_VALID=0 throughout.
- All zeros: K=32'h00000000, K_VALID=1. Required one cycle later: K0..K3=00, SUB_VALID=1, KPAR=0 if enabled.
- All ones (even parity): K=32'hFFFFFFFF. Required: K0..K3=FF.
- Even parity: K=32'h57A336BC. Required: K0=6B, K1=33, K2=7A, K3=5C, KPAR=0.
- Odd parity with hold:
  - Stimulus: K=32'h35AB674F with K_VALID=1, then K_VALID=0 and K=32'h00000000 for 3 cycles.
  - Required: K0=4F, K1=67, K2=AB, K3=35, KPAR=1; the values hold while SUB_VALID drops to 0.
- Back-to-back: 32'h57A336BC then 32'h35AB674F on consecutive cycles, then RST asserted mid-stream. Required: two consecutive SUB_VALID cycles with the values above, and outputs cleared on the RST edge.
